video_line_sequencer: RTL and testbench

Sequences binarized pixel rows into the digit-recognition line datapath.
- Accepts a serial 1-bit pixel stream with a valid/ready handshake and packs each row into a WE-bit word.
- Presents the current row on `line1` and the previous row on `line2`, with the row index on `h`, then pulses `line_clk`.
- Holds all three stable for the recognizer's full column scan before issuing the next row.
- After the last row it signals frame completion, so downstream result registers are sampled only once per frame.

---
 rtl/video_pkg.sv | 24 ++
 rtl/video_line_packer.sv | 84 ++++++++
 rtl/video_line_sequencer.sv | 163 ++++++++++++++++
 tb/tb_video_line_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : video_pkg
//  Description : Shared types and default frame geometry for the video line
//                sequencer and the digit recognizer it feeds.
//  Revision    : 1.0 - initial release
// ============================================================================
package video_pkg;

  // Row sequencer states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    ISSUE = 3'd2,
    SCAN  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Frame geometry shared with the recognizer so line widths cannot diverge
  localparam int c_WE_DEFAULT = 180;
  localparam int c_HE_DEFAULT = 240;

endpackage
`default_nettype wire

// File: rtl/video_line_packer.sv
`default_nettype none
// ============================================================================
//  Module      : video_line_packer
//  Description : Serial-to-parallel row buffer. Owns the pixel accept logic,
//                the column counter and the row-complete flag. o_row_next is
//                the buffer contents including the pixel accepted this cycle,
//                so a row can be issued on the same edge that stores its
//                last pixel.
//  Revision    : 1.0 - initial release
// ============================================================================
module video_line_packer
  import video_pkg::*;
#(
  parameter int WE = c_WE_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_pix,
  input  logic          i_valid,
  input  logic          i_sof,
  input  logic          i_intake_en,  // current state allows intake
  input  logic          i_collect,    // store non-SOF pixels (low in IDLE)
  input  logic          i_clr,        // row consumed: reset column and full flag
  output logic          o_ready,
  output logic          o_restart,    // accepted pixel carries SOF
  output logic          o_last,       // accepted pixel completes the row
  output logic          o_full,
  output logic [WE-1:0] o_row_next
);

  localparam int            c_COL_W    = (WE > 1) ? $clog2(WE) : 1;
  localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(WE - 1);

  logic [c_COL_W-1:0] r_col;
  logic [WE-1:0]      r_row;
  logic               r_full;
  logic               w_accept;
  logic               w_store;

  // A completed row blocks intake until it has been issued
  assign o_ready   = i_intake_en & ~r_full;
  assign w_accept  = i_valid & o_ready;
  assign o_restart = w_accept & i_sof;
  assign w_store   = w_accept & ~i_sof & i_collect;
  assign o_last    = w_store & (r_col == c_COL_LAST);
  assign o_full    = r_full;

  // Merge the pixel being accepted into the buffered row
  always_comb begin
    o_row_next = r_row;
    if (o_restart) begin
      o_row_next[0] = i_pix;
    end else if (w_store) begin
      o_row_next[r_col] = i_pix;
    end
  end

  // Row buffer, column counter and row-complete flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_row  <= '0;
      r_col  <= '0;
      r_full <= 1'b0;
    end else begin
      r_row <= o_row_next;
      if (i_clr) begin
        r_col  <= '0;
        r_full <= 1'b0;
      end else if (o_restart) begin
        r_col  <= c_COL_W'(1);
        r_full <= 1'b0;
      end else if (w_store) begin
        if (r_col == c_COL_LAST) begin
          r_col  <= '0;
          r_full <= 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/video_line_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : video_line_sequencer
//  Description : Packs a serial binarized pixel stream into rows and issues
//                them (current + previous row, row index) to the recognizer
//                with a line_clk strobe, holding each row for a full column
//                scan. Signals frame_done once per frame.
//                Optional macro VIDEO_LINE_DBUF_EN lets the next row fill
//                during the scan window.
//  Revision    : 1.0 - initial release
// ============================================================================
module video_line_sequencer
  import video_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int WE          = c_WE_DEFAULT,
  parameter int HE          = c_HE_DEFAULT,
  parameter int SCAN_CYCLES = WE + 2
) (
  input  logic                  video_clk,
  input  logic                  rst,
  input  logic                  pix_in,
  input  logic                  pix_valid,
  input  logic                  pix_sof,
  output logic                  pix_ready,
  output logic                  line_clk,
  output logic [WE-1:0]         line1,
  output logic [WE-1:0]         line2,
  output logic [DATA_WIDTH-1:0] h,
  output logic                  frame_done,
  output logic                  busy,
  output logic                  err_sof
);

`ifdef VIDEO_LINE_DBUF_EN
  localparam bit c_DBUF = 1'b1;
`else
  localparam bit c_DBUF = 1'b0;
`endif
  localparam int                    c_SCAN_W    = $clog2(SCAN_CYCLES + 1);
  localparam logic [c_SCAN_W-1:0]   c_SCAN_LAST = c_SCAN_W'(SCAN_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] c_ROW_LAST  = DATA_WIDTH'(HE - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [c_SCAN_W-1:0]   r_scan;
  logic [DATA_WIDTH-1:0] r_row;
  logic [DATA_WIDTH-1:0] w_row_d;
  logic [WE-1:0]         r_line1;
  logic [WE-1:0]         r_line2;
  logic [DATA_WIDTH-1:0] r_h;
  logic                  r_line_clk;
  logic                  r_frame_done;
  logic                  r_busy;
  logic                  r_err_sof;
  logic                  w_intake_en;
  logic                  w_restart;
  logic                  w_last;
  logic                  w_full;
  logic                  w_expire;
  logic                  w_h_last;
  logic [WE-1:0]         w_row_next;

  // Intake is open in IDLE/FILL, and in SCAN when double buffering
  assign w_intake_en = ~rst & ((r_state == IDLE) || (r_state == FILL) ||
                               (c_DBUF && (r_state == SCAN)));

  video_line_packer #(
    .WE (WE)
  ) u_packer (
    .clk         (video_clk),
    .rst         (rst),
    .i_pix       (pix_in),
    .i_valid     (pix_valid),
    .i_sof       (pix_sof),
    .i_intake_en (w_intake_en),
    .i_collect   (r_state != IDLE),
    .i_clr       ((r_state == ISSUE) || (r_state == DONE)),
    .o_ready     (pix_ready),
    .o_restart   (w_restart),
    .o_last      (w_last),
    .o_full      (w_full),
    .o_row_next  (w_row_next)
  );

  assign w_expire = (r_state == SCAN) && (r_scan == c_SCAN_LAST);
  assign w_h_last = (r_h == c_ROW_LAST);
  assign w_row_d  = w_restart               ? '0 :
                    (w_expire && !w_h_last) ? r_row + 1'b1 : r_row;

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (w_restart) w_state_nxt = FILL;
      FILL:  if (w_last) w_state_nxt = ISSUE;
      ISSUE: w_state_nxt = SCAN;
      SCAN: begin
        if (w_restart) begin
          w_state_nxt = FILL;
        end else if (w_expire) begin
          if (w_h_last)              w_state_nxt = DONE;
          else if (w_full || w_last) w_state_nxt = ISSUE;
          else                       w_state_nxt = FILL;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge video_clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Row counter and scan-window counter
  always_ff @(posedge video_clk) begin
    if (rst) begin
      r_row  <= '0;
      r_scan <= '0;
    end else begin
      r_row  <= w_row_d;
      r_scan <= (r_state == SCAN) ? r_scan + 1'b1 : '0;
    end
  end

  // Output registers: strobes follow the next state, row data loads entering ISSUE
  always_ff @(posedge video_clk) begin
    if (rst) begin
      r_line1      <= '0;
      r_line2      <= '0;
      r_h          <= '0;
      r_line_clk   <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
      r_err_sof    <= 1'b0;
    end else begin
      r_line_clk   <= (w_state_nxt == ISSUE);
      r_frame_done <= (w_state_nxt == DONE);
      r_busy       <= (w_state_nxt != IDLE);
      r_err_sof    <= w_restart && (r_state != IDLE);
      if (w_restart) begin
        r_line1 <= '0;
      end else if (w_state_nxt == ISSUE) begin
        r_line2 <= r_line1;
        r_line1 <= w_row_next;
        r_h     <= w_row_d;
      end
    end
  end

  assign line_clk   = r_line_clk;
  assign line1      = r_line1;
  assign line2      = r_line2;
  assign h          = r_h;
  assign frame_done = r_frame_done;
  assign busy       = r_busy;
  assign err_sof    = r_err_sof;

endmodule
`default_nettype wire

// File: tb/tb_video_line_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_video_line_sequencer
//  Description : Scoreboard bench for video_line_sequencer (WE=8, HE=4,
//                SCAN_CYCLES=10). Stimulus queues expected rows; a monitor
//                compares them on every line_clk.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_video_line_sequencer;

  localparam int DW = 8;
  localparam int WE = 8;
  localparam int HE = 4;
  localparam int SC = 10;
`ifdef VIDEO_LINE_DBUF_EN
  localparam int SPACING = 11;
`else
  localparam int SPACING = 19;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pix_in = 1'b0;
  logic          pix_valid = 1'b0;
  logic          pix_sof = 1'b0;
  logic          pix_ready;
  logic          line_clk;
  logic [WE-1:0] line1;
  logic [WE-1:0] line2;
  logic [DW-1:0] h;
  logic          frame_done;
  logic          busy;
  logic          err_sof;

  always #5 clk = ~clk;

  video_line_sequencer #(
    .DATA_WIDTH  (DW),
    .WE          (WE),
    .HE          (HE),
    .SCAN_CYCLES (SC)
  ) dut (
    .video_clk  (clk),
    .rst        (rst),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_sof    (pix_sof),
    .pix_ready  (pix_ready),
    .line_clk   (line_clk),
    .line1      (line1),
    .line2      (line2),
    .h          (h),
    .frame_done (frame_done),
    .busy       (busy),
    .err_sof    (err_sof)
  );

  typedef struct packed {
    logic [WE-1:0] l1;
    logic [WE-1:0] l2;
    logic [DW-1:0] h;
  } line_t;

  line_t exp_q[$];
  int    exp_fd      = 0;
  int    exp_err     = 0;
  int    checks      = 0;
  int    errors      = 0;
  int    cyc         = 0;
  int    last_lc     = -1;
  int    lc_seen     = 0;
  int    win         = 0;
  bit    chk_spacing = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops the scoreboard on every output strobe
  always @(negedge clk) begin
    line_t e;
    cyc = cyc + 1;
    if (rst) begin
      win = 0;
    end else if (win > 0) begin
`ifndef VIDEO_LINE_DBUF_EN
      chk("pix_ready_in_scan", {63'd0, pix_ready}, 64'd0);
`endif
      win = win - 1;
    end
    if (line_clk === 1'b1) begin
      lc_seen = lc_seen + 1;
      if (exp_q.size() == 0) begin
        fail_evt("unexpected_line_clk");
      end else begin
        e = exp_q.pop_front();
        chk("line1", {56'd0, line1}, {56'd0, e.l1});
        chk("line2", {56'd0, line2}, {56'd0, e.l2});
        chk("h", {56'd0, h}, {56'd0, e.h});
      end
      if (chk_spacing && last_lc >= 0)
        chk("line_clk_spacing", 64'(cyc - last_lc), 64'(SPACING));
`ifndef VIDEO_LINE_DBUF_EN
      chk("pix_ready_in_issue", {63'd0, pix_ready}, 64'd0);
`endif
      win     = SC;
      last_lc = cyc;
    end
    if (frame_done === 1'b1) begin
      if (exp_fd == 0) begin
        fail_evt("unexpected_frame_done");
      end else begin
        exp_fd = exp_fd - 1;
        chk("frame_done_delay", 64'(cyc - last_lc), 64'(SC + 1));
      end
    end
    if (err_sof === 1'b1) begin
      if (exp_err == 0) fail_evt("unexpected_err_sof");
      else begin
        exp_err = exp_err - 1;
        checks++;
      end
    end
  end

  // One pixel handshake; ready is sampled mid-cycle, away from the edge
  task automatic send(input logic p, input logic sof, input bit gaps);
    int n;
    bit acc;
    if (gaps && ($urandom_range(0, 1) == 1)) begin
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
      @(posedge clk);
      #1;
    end
    pix_in    = p;
    pix_sof   = sof;
    pix_valid = 1'b1;
    n   = 0;
    acc = 1'b0;
    do begin
      @(negedge clk);
      acc = pix_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: got no ready expected ready within 200 cycles");
    end
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic send_row(input logic [WE-1:0] v, input bit sof, input bit gaps, input int ncols);
    for (int c = 0; c < ncols; c++) send(v[c], sof && (c == 0), gaps);
  endtask

  task automatic send_frame(input logic [4*WE-1:0] rows, input bit gaps);
    line_t         e;
    logic [WE-1:0] prev;
    logic [WE-1:0] cur;
    prev = '0;
    for (int r = 0; r < HE; r++) begin
      cur  = rows[(HE-1-r)*WE +: WE];
      e.l1 = cur;
      e.l2 = prev;
      e.h  = DW'(r);
      exp_q.push_back(e);
      prev = cur;
    end
    exp_fd++;
    for (int r = 0; r < HE; r++) send_row(rows[(HE-1-r)*WE +: WE], r == 0, gaps, WE);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() > 0 || exp_fd > 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_pending", 64'(exp_q.size() + exp_fd), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    line_t e;
    int    base;
    int    n;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pix_ready", {63'd0, pix_ready}, 64'd0);
    chk("rst_line_clk", {63'd0, line_clk}, 64'd0);
    chk("rst_line1", {56'd0, line1}, 64'd0);
    chk("rst_line2", {56'd0, line2}, 64'd0);
    chk("rst_h", {56'd0, h}, 64'd0);
    chk("rst_frame_done", {63'd0, frame_done}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_err_sof", {63'd0, err_sof}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", {63'd0, busy}, 64'd0);
    chk("idle_pix_ready", {63'd0, pix_ready}, 64'd1);
    @(posedge clk);
    #1;

    // Full gap-free frame
    last_lc     = -1;
    chk_spacing = 1'b1;
    send_frame({8'h0F, 8'hF0, 8'hAA, 8'h55}, 1'b0);
    wait_drain();
    chk_spacing = 1'b0;
    chk("post_frame_busy", {63'd0, busy}, 64'd0);

    // Mid-frame restart at row 1, column 5
    e.l1 = 8'h0F; e.l2 = 8'h00; e.h = 8'd0;
    exp_q.push_back(e);
    send_row(8'h0F, 1'b1, 1'b0, WE);
    send_row(8'hF0, 1'b0, 1'b0, 5);
    exp_err++;
    send_frame({8'h3C, 8'hC3, 8'h81, 8'h7E}, 1'b0);
    wait_drain();

    // Backpressure: same rows with random valid gaps
    send_frame({8'h0F, 8'hF0, 8'hAA, 8'h55}, 1'b1);
    wait_drain();

    // Reset during the scan of row 2
    base = lc_seen;
    e.l1 = 8'h11; e.l2 = 8'h00; e.h = 8'd0; exp_q.push_back(e);
    e.l1 = 8'h22; e.l2 = 8'h11; e.h = 8'd1; exp_q.push_back(e);
    e.l1 = 8'h33; e.l2 = 8'h22; e.h = 8'd2; exp_q.push_back(e);
    send_row(8'h11, 1'b1, 1'b0, WE);
    send_row(8'h22, 1'b0, 1'b0, WE);
    send_row(8'h33, 1'b0, 1'b0, WE);
    n = 0;
    while (lc_seen < base + 3 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("row2_issued", 64'(lc_seen - base), 64'd3);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_scan_line1", {56'd0, line1}, 64'd0);
    chk("rst_scan_line2", {56'd0, line2}, 64'd0);
    chk("rst_scan_h", {56'd0, h}, 64'd0);
    chk("rst_scan_busy", {63'd0, busy}, 64'd0);
    repeat (40) @(posedge clk);
    #1;
    send_frame({8'hE7, 8'h18, 8'h3C, 8'h99}, 1'b0);
    wait_drain();

    chk("err_sof_pending", 64'(exp_err), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
